// File: rtl/round_key_memory_if.sv
// Bus bundle for the round-key store: write strobe, shared address, write data, read data.
interface round_key_memory_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output we, output addr, output din, input dout);
  modport slave  (input we, input addr, input din, output dout);
endinterface

// File: rtl/round_key_memory.sv
// Single-port round-key store: synchronous write, registered read-first read,
// asynchronous clear of every entry and of the read register.
module round_key_memory #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 11,
  parameter int ADDR_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  round_key_memory_if.slave  bus
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;
  logic                  addr_in_range;

  // Zero-extend the address before comparing so DEPTH == 2**ADDR_WIDTH still works.
  assign addr_in_range = int'(bus.addr) < DEPTH;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    mem_d  = mem_q;
    dout_d = '0;
    if (addr_in_range) begin
      // Read sees mem_q, i.e. the pre-write contents: read-first behaviour.
      dout_d = mem_q[bus.addr];
      if (bus.we) begin
        mem_d[bus.addr] = bus.din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the key store itself is cleared on reset (keys must not survive it), so it is
      // built from resettable flops rather than an inferred RAM macro.
      mem_q  <= '{default: '0};
      dout_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state, so every flop samples pre-edge values.
      mem_q  <= mem_d;
      dout_q <= dout_d;
    end
  end

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_round_key_memory.sv
// Directed bench for round_key_memory: vector table for write/read/boundary behaviour,
// hand sequences for hold-between-edges, reset clearing and writes coinciding with reset.
module tb_round_key_memory;

  localparam int DW = 128;
  localparam int AW = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  round_key_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  round_key_memory #(.DATA_WIDTH(DW), .DEPTH(11), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
    string         name;
  } vec_t;

  vec_t vecs[$];

  localparam logic [DW-1:0] KEY3 = 128'h0000_0000_0000_0000_DEAD_BEEF_1234_5678;
  localparam logic [DW-1:0] KEY7 = 128'h0000_0000_0000_0000_CAFE_BABE_8765_4321;
  localparam logic [DW-1:0] VA   = 128'h5555_AAAA_0F0F_F0F0_1357_9BDF_2468_ACE0;
  localparam logic [DW-1:0] VB   = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] VW   = 128'h8000_0001_FFFF_0000_0000_FFFF_1000_0008;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, leave sampling to the caller.
  task automatic step(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    @(negedge clk);
    bus.we   = we;
    bus.addr = addr;
    bus.din  = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.din  = '0;

    vecs.push_back('{1'b1, 4'd3,  KEY3,      128'h0,    "wr3_readfirst_empty"});
    vecs.push_back('{1'b0, 4'd3,  128'h0,    KEY3,      "rd3"});
    vecs.push_back('{1'b1, 4'd7,  KEY7,      128'h0,    "wr7"});
    vecs.push_back('{1'b0, 4'd7,  128'h0,    KEY7,      "rd7"});
    vecs.push_back('{1'b0, 4'd3,  128'h0,    KEY3,      "rd3_again"});
    vecs.push_back('{1'b1, 4'd5,  VA,        128'h0,    "wr5_A"});
    vecs.push_back('{1'b1, 4'd5,  VB,        VA,        "wr5_B_readfirst"});
    vecs.push_back('{1'b0, 4'd5,  128'h0,    VB,        "rd5_B"});
    vecs.push_back('{1'b1, 4'd0,  128'h11,   128'h0,    "wr0"});
    vecs.push_back('{1'b1, 4'd10, 128'hAA,   128'h0,    "wr10"});
    vecs.push_back('{1'b1, 4'd12, 128'hFF,   128'h0,    "wr12_oob"});
    vecs.push_back('{1'b1, 4'd15, 128'hEE,   128'h0,    "wr15_oob"});
    vecs.push_back('{1'b0, 4'd0,  128'h0,    128'h11,   "rd0"});
    vecs.push_back('{1'b0, 4'd10, 128'hAA,   128'hAA,   "rd10"});
    vecs.push_back('{1'b0, 4'd12, 128'h0,    128'h0,    "rd12_oob"});
    vecs.push_back('{1'b0, 4'd1,  128'h0,    128'h0,    "rd1_no_alias"});
    vecs.push_back('{1'b0, 4'd4,  128'h0,    128'h0,    "rd4_no_alias"});
    vecs.push_back('{1'b1, 4'd9,  VW,        128'h0,    "wr9_full_width"});
    vecs.push_back('{1'b0, 4'd9,  128'h0,    VW,        "rd9_full_width"});
    vecs.push_back('{1'b0, 4'd11, 128'h0,    128'h0,    "rd11_oob"});
    vecs.push_back('{1'b0, 4'd7,  128'h0,    KEY7,      "rd7_retained"});

    // Reset held across clock edges, including one with a write attempt.
    bus.we   = 1'b1;
    bus.addr = 4'd2;
    bus.din  = 128'h77;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", bus.dout, '0);
    @(negedge clk);
    bus.we = 1'b0;
    rst_n  = 1'b1;
    step(1'b0, 4'd2, '0);
    check("reset_write_discarded", bus.dout, '0);

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].addr, vecs[i].din);
      check(vecs[i].name, bus.dout, vecs[i].exp);
    end

    // dout must not follow addr/we/din between edges.
    @(negedge clk);
    bus.addr = 4'd3;
    bus.we   = 1'b1;
    bus.din  = VB;
    #2;
    check("hold_between_edges", bus.dout, KEY7);
    @(posedge clk);
    #1;
    check("hold_wr3_readfirst", bus.dout, KEY3);
    step(1'b0, 4'd3, '0);
    check("rd3_overwritten", bus.dout, VB);

    // Fill every entry with nonzero data, then reset mid-cycle.
    for (int i = 0; i < 11; i++) step(1'b1, AW'(i), {4{32'(i + 1)}});
    step(1'b0, 4'd4, '0);
    check("fill_rd4", bus.dout, {4{32'd5}});
    @(negedge clk);
    bus.we   = 1'b1;
    bus.addr = 4'd6;
    bus.din  = VA;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_dout", bus.dout, '0);
    @(posedge clk);
    #1;
    check("reset_during_write_edge", bus.dout, '0);
    @(negedge clk);
    bus.we = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(1'b0, AW'(i), '0);
      check($sformatf("post_reset_rd%0d", i), bus.dout, '0);
    end

    // Operation resumes normally after reset.
    step(1'b1, 4'd8, KEY3);
    step(1'b0, 4'd8, '0);
    check("post_reset_wr_rd8", bus.dout, KEY3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_key_memory.md
ROUND_KEY_MEMORY -- requirements
Module: round_key_memory

Interface
REQ-001 The block SHALL be a single-port, 11-entry by 128-bit round-key store with synchronous write and registered read.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 128: width of each entry, din and dout.
REQ-003 The block SHALL have parameter DEPTH, default 11: number of entries, holding round keys 0..10.
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 4: width of addr; SHALL satisfy 2**ADDR_WIDTH >= DEPTH.
REQ-005 The block SHALL have port clk, input, 1 bit: the one clock; all state changes on its rising edge except reset.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port we, input, 1 bit: write enable, sampled on the rising edge of clk.
REQ-008 The block SHALL have port addr, input, ADDR_WIDTH bits: entry index for both write and read.
REQ-009 The block SHALL have port din, input, DATA_WIDTH bits: write data.
REQ-010 The block SHALL have port dout, output, DATA_WIDTH bits: registered read data.

Function
REQ-011 Write: at a rising clk edge with rst_n=1, we=1 and addr<DEPTH, the entry mem[addr] SHALL take the value of din.
REQ-012 Out-of-range write: with we=1 and addr>=DEPTH, the block SHALL leave every entry unchanged.
REQ-013 Read: at every rising clk edge with rst_n=1, dout SHALL load mem[addr] when addr<DEPTH, or all-zero when addr>=DEPTH; this gives one-cycle latency.
REQ-014 The read SHALL occur every cycle regardless of we; there is no read enable.
REQ-015 Same-cycle write and read of the same address SHALL be read-first: dout shows the entry's pre-write contents, and the new data appears one edge later if addr is held.
REQ-016 Between edges, dout SHALL hold its last registered value and SHALL NOT change combinationally with addr, we or din.
REQ-017 Entries SHALL hold their contents indefinitely until overwritten or reset.
REQ-018 Narrower din values written (e.g. 64-bit literals) SHALL be stored zero-extended to the full DATA_WIDTH.

Reset
REQ-019 While rst_n=0, dout SHALL be all-zero and every entry 0..DEPTH-1 SHALL be all-zero, independent of clk.
REQ-020 A write edge that coincides with rst_n=0 SHALL be discarded.
REQ-021 Assertion of rst_n mid-operation SHALL immediately clear dout and all entries.
REQ-022 After rst_n deasserts, operation SHALL begin at the first rising clk edge with rst_n=1.

Verification
REQ-023 Write then read: write addr=3, din=128'h0000_0000_0000_0000_DEAD_BEEF_1234_5678; then set we=0, addr=3; after the next edge, dout SHALL equal 128'h...DEADBEEF12345678, upper 64 bits zero.
REQ-024 Second entry: write addr=7, din=128'hCAFEBABE87654321; read addr=7 -> dout SHALL equal 128'h...CAFEBABE87654321; a following read of addr=3 SHALL still return DEADBEEF12345678.
REQ-025 Read-first: with mem[5]=A, apply we=1, addr=5, din=B for one edge -> dout SHALL equal A after that edge, then B after the next edge with we=0, addr=5.
REQ-026 Boundaries: write 0x11 to addr 0 and 0xAA to addr 10, then attempt a write to addr 12 -> reads of addr 0 and addr 10 SHALL return 0x11 and 0xAA, and a read of addr 12 SHALL return 0.
REQ-027 Reset: fill addr 0..10 with nonzero data, then pulse rst_n low between clock edges -> dout SHALL be 0 at once, and every address read after release SHALL return 0.
